bnn_uart_rx: RTL and testbench

BNN_UART_RX -- requirements
Module: bnn_uart_rx

---
 rtl/bnn_pkg.sv | 16 +
 rtl/bnn_byte_fifo.sv | 57 +++++
 rtl/bnn_uart_rx.sv | 178 +++++++++++++++++
 tb/tb_bnn_uart_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN serial front end: receiver state encoding
// and default link/buffer sizing.
package bnn_pkg;

  localparam int BNN_CLKS_PER_BIT  = 87;
  localparam int BNN_RX_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/bnn_byte_fifo.sv
// Small byte buffer between the UART receiver and the BNN controller.
// Head is read straight from storage; a pushed byte is visible the cycle after.
module bnn_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A pop frees the head slot, so a push into a full buffer still fits.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign head_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/bnn_uart_rx.sv
// 8N1 UART receiver feeding a byte buffer, with advisory CTS flow control
// and single-cycle frame/overrun error pulses.
module bnn_uart_rx
  import bnn_pkg::*;
#(
  parameter int CLKS_PER_BIT = BNN_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = BNN_RX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_cts,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [9:0]      HALF_LOAD = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0]      BIT_LOAD  = 10'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CTS_LIMIT = CW'(FIFO_DEPTH - 2);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push;
  logic          stop_bad;
  logic          frame_err_q;
  logic          overrun_q;
  logic          cts_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          pop_fire;
  logic          push_ok;
  logic [CW-1:0] occ_next;

  assign rx_s = sync2_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (tick) begin
          // Still low at mid start bit: real frame; otherwise a line glitch.
          if (!rx_s) begin
            state_d   = RX_DATA;
            cnt_d     = BIT_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = BIT_LOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = RX_WAIT_IDLE;
            cnt_d    = BIT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        // Any low sample restarts the full bit-time of required idle.
        if (!rx_s) begin
          cnt_d = BIT_LOAD;
        end else if (tick) begin
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  bnn_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (m_ready),
    .head_o      (m_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign m_valid  = ~fifo_empty;
  assign pop_fire = m_ready & ~fifo_empty;
  assign push_ok  = push & (~fifo_full | pop_fire);
  assign occ_next = fifo_count + CW'(push_ok) - CW'(pop_fire);

  // CTS looks at next-cycle occupancy so one in-flight byte always has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cts_q       <= (occ_next <= CTS_LIMIT);
      frame_err_q <= stop_bad;
      overrun_q   <= push & fifo_full & ~pop_fire;
    end
  end

  assign uart_cts    = cts_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_bnn_uart_rx.sv
// Randomized self-checking bench for bnn_uart_rx with 8 clocks per bit and a
// 4-entry buffer; expected bytes come from a simple queue model of the link.
module tb_bnn_uart_rx;

  localparam int C = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       uart_cts;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       frame_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_q[$];
  int   fe_cnt    = 0;
  int   ov_cnt    = 0;
  int   vcyc      = 0;
  int   last_rise = 0;
  logic mv_prev   = 1'b0;

  bnn_uart_rx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .uart_cts    (uart_cts),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and pulses just before the edge that acts on them.
  always @(negedge clk) begin
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun_err) ov_cnt <= ov_cnt + 1;
    if (m_valid) vcyc <= vcyc + 1;
    if (m_valid && !mv_prev) last_rise <= cyc;
    mv_prev <= m_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    $display("tx frame data=%02h stop=%0d at cycle %0d", b, stop, cyc);
    uart_rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(C);
    end
    uart_rx = stop;
    wait_cycles(C);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    uart_rx = 1'b1;
    m_ready = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got=%02h exp=00", m_data); end
    n_checks++; if (uart_cts !== 1'b0) begin n_fail++; $display("FAIL reset_cts got=%b exp=0", uart_cts); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun_err); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_checks++; if (uart_cts !== 1'b0) begin n_fail++; $display("FAIL cts_before_edge got=%b exp=0", uart_cts); end
    @(posedge clk); #1;
    n_checks++; if (uart_cts !== 1'b1) begin n_fail++; $display("FAIL cts_first_edge got=%b exp=1", uart_cts); end
    $display("reset sequence done at cycle %0d", cyc);
  endtask

  task automatic test_single_byte();
    int b0 = got_q.size();
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    int v0 = vcyc;
    int s  = cyc;
    int lat;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_cycles(2 * C);
    lat = last_rise - s;
    n_checks++; if (got_q.size() != b0 + 1) begin n_fail++; $display("FAIL a5_count got=%0d exp=1", got_q.size() - b0); end
    else begin
      n_checks++; if (got_q[b0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data got=%02h exp=a5", got_q[b0]); end
    end
    n_checks++; if (vcyc - v0 != 1) begin n_fail++; $display("FAIL a5_valid_cycles got=%0d exp=1", vcyc - v0); end
    n_checks++; if (lat < 78 || lat > 81) begin n_fail++; $display("FAIL a5_latency got=%0d exp=78..81", lat); end
    n_checks++; if (fe_cnt != f0 || ov_cnt != o0) begin n_fail++; $display("FAIL a5_errors got fe=%0d ov=%0d exp 0/0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  task automatic test_random_bytes();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int b0 = got_q.size();
    int f0 = fe_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      wait_cycles(C * $urandom_range(0, 2));
    end
    wait_cycles(2 * C);
    n_checks++; if (got_q.size() != b0 + 8) begin n_fail++; $display("FAIL rand_count got=%0d exp=8", got_q.size() - b0); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_q[b0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d got=%02h exp=%02h", i, got_q[b0 + i], exp_q[i]); end
      end
    end
    n_checks++; if (fe_cnt != f0) begin n_fail++; $display("FAIL rand_frame_err got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_frame_error();
    int b0 = got_q.size();
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    int v0 = vcyc;
    m_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    wait_cycles(C);
    n_checks++; if (vcyc != v0) begin n_fail++; $display("FAIL ferr_valid got=%0d exp=0 cycles", vcyc - v0); end
    n_checks++; if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - f0); end
    send_frame(8'h81, 1'b1);
    wait_cycles(2 * C);
    n_checks++; if (got_q.size() != b0 + 1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", got_q.size() - b0); end
    else begin
      n_checks++; if (got_q[b0] !== 8'h81) begin n_fail++; $display("FAIL ferr_next_byte got=%02h exp=81", got_q[b0]); end
    end
    n_checks++; if (fe_cnt - f0 != 1 || ov_cnt != o0) begin n_fail++; $display("FAIL ferr_totals got fe=%0d ov=%0d exp 1/0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  task automatic test_glitch();
    int b0 = got_q.size();
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    logic [7:0] b = 8'($urandom);
    m_ready = 1'b1;
    uart_rx = 1'b0;
    wait_cycles(3);
    uart_rx = 1'b1;
    wait_cycles(3 * C);
    $display("glitch applied at cycle %0d", cyc);
    n_checks++; if (got_q.size() != b0 || fe_cnt != f0 || ov_cnt != o0) begin
      n_fail++; $display("FAIL glitch_quiet got bytes=%0d fe=%0d ov=%0d exp 0/0/0", got_q.size() - b0, fe_cnt - f0, ov_cnt - o0);
    end
    send_frame(b, 1'b1);
    wait_cycles(2 * C);
    n_checks++; if (got_q.size() != b0 + 1) begin n_fail++; $display("FAIL glitch_after_count got=%0d exp=1", got_q.size() - b0); end
    else begin
      n_checks++; if (got_q[b0] !== b) begin n_fail++; $display("FAIL glitch_after_byte got=%02h exp=%02h", got_q[b0], b); end
    end
  endtask

  task automatic test_flow_control();
    int b0 = got_q.size();
    int o0 = ov_cnt;
    int occ = 0;
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1);
      wait_cycles(C);
      if (occ < D) occ++;
      n_checks++; if (uart_cts !== (occ <= D - 2)) begin n_fail++; $display("FAIL flow_cts_byte%0d got=%b exp=%b", k, uart_cts, occ <= D - 2); end
      n_checks++; if (ov_cnt - o0 != (k == 5 ? 1 : 0)) begin n_fail++; $display("FAIL flow_overrun_byte%0d got=%0d exp=%0d", k, ov_cnt - o0, k == 5 ? 1 : 0); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin n_fail++; $display("FAIL flow_hold got v=%b d=%02h exp v=1 d=01", m_valid, m_data); end
      wait_cycles(1);
    end
    for (int k = 0; k < 4; k++) begin
      m_ready = 1'b1;
      wait_cycles(1);
      m_ready = 1'b0;
      occ--;
      n_checks++; if (uart_cts !== (occ <= D - 2)) begin n_fail++; $display("FAIL flow_drain_cts%0d got=%b exp=%b", k, uart_cts, occ <= D - 2); end
    end
    n_checks++; if (got_q.size() != b0 + 4) begin n_fail++; $display("FAIL flow_drain_count got=%0d exp=4", got_q.size() - b0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (got_q[b0 + k] !== 8'(k + 1)) begin n_fail++; $display("FAIL flow_drain_byte%0d got=%02h exp=%02h", k, got_q[b0 + k], 8'(k + 1)); end
      end
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flow_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int b0 = got_q.size();
    int o0 = ov_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      wait_cycles(C);
    end
    n_checks++; if (uart_cts !== 1'b0 || m_valid !== 1'b1) begin n_fail++; $display("FAIL full_pre got cts=%b v=%b exp cts=0 v=1", uart_cts, m_valid); end
    b = 8'($urandom);
    exp_q.push_back(b);
    // The stop bit is accepted 79 edges after the start bit is driven.
    fork
      send_frame(b, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    wait_cycles(C);
    n_checks++; if (ov_cnt != o0) begin n_fail++; $display("FAIL full_overrun got=%0d exp=0", ov_cnt - o0); end
    n_checks++; if (got_q.size() != b0 + 1) begin n_fail++; $display("FAIL full_pop_count got=%0d exp=1", got_q.size() - b0); end
    n_checks++; if (uart_cts !== 1'b0 || m_valid !== 1'b1) begin n_fail++; $display("FAIL full_post got cts=%b v=%b exp cts=0 v=1", uart_cts, m_valid); end
    for (int i = 0; i < 4; i++) begin
      m_ready = 1'b1;
      wait_cycles(1);
      m_ready = 1'b0;
    end
    n_checks++; if (got_q.size() != b0 + 5) begin n_fail++; $display("FAIL full_total got=%0d exp=5", got_q.size() - b0); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (got_q[b0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order%0d got=%02h exp=%02h", i, got_q[b0 + i], exp_q[i]); end
      end
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial = 8'h55;
    int b0;
    int f0;
    int o0;
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_cycles(2 * C);
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_pre got v=%b d=%02h exp v=1 d=5a", m_valid, m_data); end
    uart_rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 4; i++) begin
      uart_rx = partial[i];
      wait_cycles(C);
    end
    #3 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-frame at cycle %0d", cyc);
    n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out got v=%b d=%02h exp v=0 d=00", m_valid, m_data); end
    n_checks++; if (uart_cts !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags got cts=%b fe=%b ov=%b exp 0/0/0", uart_cts, frame_err, overrun_err);
    end
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    b0 = got_q.size();
    f0 = fe_cnt;
    o0 = ov_cnt;
    m_ready = 1'b1;
    wait_cycles(2 * C);
    send_frame(8'hC3, 1'b1);
    wait_cycles(2 * C);
    n_checks++; if (got_q.size() != b0 + 1) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size() - b0); end
    else begin
      n_checks++; if (got_q[b0] !== 8'hC3) begin n_fail++; $display("FAIL rstmid_byte got=%02h exp=c3", got_q[b0]); end
    end
    n_checks++; if (fe_cnt != f0 || ov_cnt != o0) begin n_fail++; $display("FAIL rstmid_errors got fe=%0d ov=%0d exp 0/0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  initial begin
    test_reset();
    wait_cycles(2);
    test_single_byte();
    test_random_bytes();
    test_frame_error();
    test_glitch();
    test_flow_control();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
